// File: rtl/uart_rx_core_if.sv
// Output bundle of uart_rx_core: delivered word, its one-cycle strobe, error flags and busy.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (output data, data_valid, frame_err, parity_err, busy);
    modport slave  (input  data, data_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive framer: picks one 16x divider output, oversamples rx and delivers one word per frame.
// Optional parity bit between data and stop is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r1200,
    input  logic                  r2400,
    input  logic                  r4800,
    input  logic                  r9600,
    input  logic [1:0]            baud_sel,
    input  logic                  rx,
    uart_rx_core_if.master        rx_if
);
    localparam int BCW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_core: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [1:0]            sel_q, sel_d, mux_sel;
    logic                  mux, mux_q, tick;
    logic [3:0]            cnt_q, cnt_d;
    logic [BCW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                  perr_q, perr_d;
    logic                  parity_err_q, parity_err_d;
`endif

    // The divider is live in IDLE; once a frame starts the captured rate is used.
    always_comb begin
        mux_sel = (state_q == S_IDLE) ? baud_sel : sel_q;
        case (mux_sel)
            2'd0:    mux = r1200;
            2'd1:    mux = r2400;
            2'd2:    mux = r4800;
            default: mux = r9600;
        endcase
        tick = mux & ~mux_q;
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = tick ? cnt_q + 4'd1 : cnt_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    sel_d   = baud_sel;
                end
            end
            S_START: begin
                if (tick && cnt_q == 4'd7) state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && cnt_q == 4'd15) begin
                    shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BCW'(DATA_BITS - 1)) begin
                        bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d  = S_PARITY;
`else
                        state_d  = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && cnt_q == 4'd15) begin
                    perr_d  = rx_s_q ^ (^shift_q) ^ 1'(PARITY_ODD);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick && cnt_q == 4'd15) begin
                    data_d       = shift_q;
                    frame_err_d  = ~rx_s_q;
                    data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = perr_q;
`endif
                    state_d      = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: sequential state uses <= only, so every flop sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            sel_q        <= 2'd0;
            mux_q        <= 1'b0;
            cnt_q        <= 4'd0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            sel_q        <= sel_d;
            mux_q        <= mux;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.data       = data_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames are driven bit by bit and the delivered
// words are checked against expectations derived from the sent bits.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int DATA_BITS  = 8;
    localparam int PARITY_ODD = 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 fe;
        logic                 pe;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic       rx;
    logic [4:0] div_cnt = '0;
    logic       r1200, r2400, r4800, r9600;

    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    obs_t obs_q[$];

    uart_rx_core_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx_core #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
        .clk      (clk),
        .rst      (rst),
        .r1200    (r1200),
        .r2400    (r2400),
        .r4800    (r4800),
        .r9600    (r9600),
        .baud_sel (baud_sel),
        .rx       (rx),
        .rx_if    (bus)
    );

    always #5 clk = ~clk;

    // Scaled-down divider: half-periods of 2/4/8/16 clk give 64/128/256/512 clk per bit.
    always @(posedge clk) div_cnt <= div_cnt + 5'd1;
    assign r9600 = div_cnt[1];
    assign r4800 = div_cnt[2];
    assign r2400 = div_cnt[3];
    assign r1200 = div_cnt[4];

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            n_pulses++;
            obs_q.push_back({bus.data, bus.frame_err, bus.parity_err});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog expired");
    end

    function automatic int bit_clks(input logic [1:0] sel);
        return 64 << (3 - int'(sel));
    endfunction

    function automatic logic good_parity(input logic [DATA_BITS-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    // What a receiver obeying the framing rules must deliver for the given line bits.
    function automatic obs_t model(input logic [DATA_BITS-1:0] word, input logic par_bit,
                                   input logic stop_bit);
        obs_t e;
        e.data = word;
        e.fe   = !stop_bit;
        e.pe   = PAR_EN ? (par_bit != good_parity(word)) : 1'b0;
        return e;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [DATA_BITS-1:0] word, input logic par_bit, input int bc);
        drive_bit(1'b0, bc);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(word[i], bc);
        if (PAR_EN) drive_bit(par_bit, bc);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] word, input logic par_bit,
                              input logic stop_bit, input int bc);
        send_body(word, par_bit, bc);
        drive_bit(stop_bit, bc);
        drive_bit(1'b1, 8);
    endtask

    task automatic wait_frame(output obs_t o);
        int budget = 2000;
        while (obs_q.size() == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (obs_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: got no data_valid, required one within 2000 clk");
            o = 'x;
        end else begin
            o = obs_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; baud_sel = 2'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h required 00", bus.data); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.data_valid); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b required 0", bus.frame_err); end
        n_cmp++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b required 0", bus.parity_err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_basic();
        obs_t o, e;
        int   p0 = n_pulses;
        baud_sel = 2'd3;
        e = model(8'hA5, good_parity(8'hA5), 1'b1);
        send_frame(8'hA5, good_parity(8'hA5), 1'b1, bit_clks(2'd3));
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL basic_a5: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
        repeat (20) @(negedge clk);
        n_cmp++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d required 1", n_pulses - p0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_false_start();
        int p0 = n_pulses;
        baud_sel = 2'd3;
        drive_bit(1'b0, 20);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL false_busy_hi: got %b required 1", bus.busy); end
        drive_bit(1'b1, 5);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL false_busy_held: got %b required 1", bus.busy); end
        drive_bit(1'b1, 128);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL false_busy_lo: got %b required 0", bus.busy); end
        n_cmp++; if (n_pulses - p0 !== 0) begin n_fail++; $display("FAIL false_pulses: got %0d required 0", n_pulses - p0); end
    endtask

    task automatic test_break();
        obs_t o, e;
        int   p0 = n_pulses;
        baud_sel = 2'd3;
        e = model(8'h3C, good_parity(8'h3C), 1'b0);
        send_body(8'h3C, good_parity(8'h3C), 64);
        drive_bit(1'b0, 96);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b required 1", bus.busy); end
        drive_bit(1'b0, 32);
        n_cmp++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d required 1", n_pulses - p0); end
        drive_bit(1'b1, 64);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got %b required 0", bus.busy); end
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL break_3c: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
        e = model(8'h11, good_parity(8'h11), 1'b1);
        send_frame(8'h11, good_parity(8'h11), 1'b1, 64);
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL after_break_11: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        obs_t o, e;
        baud_sel = 2'd3;
        for (int b = 0; b < 2; b++) begin
            e = model(8'h0F, 1'(b), 1'b1);
            send_frame(8'h0F, 1'(b), 1'b1, 64);
            wait_frame(o);
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL parity_0f_bit%0d: got %h/%b/%b required %h/%b/%b", b, o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
        end
    endtask
`endif

    task automatic test_baud_change();
        obs_t o, e;
        baud_sel = 2'd3;
        e = model(8'hC3, good_parity(8'hC3), 1'b1);
        fork
            send_frame(8'hC3, good_parity(8'hC3), 1'b1, bit_clks(2'd3));
            begin
                repeat (5 * 64) @(posedge clk);
                #1 baud_sel = 2'd0;
            end
        join
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL baud_hold_c3: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
        e = model(8'h9E, good_parity(8'h9E), 1'b1);
        send_frame(8'h9E, good_parity(8'h9E), 1'b1, bit_clks(2'd0));
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL baud_1200_9e: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [DATA_BITS-1:0] w;
        logic par, stp;
        int   p0;
        for (int k = 0; k < 6; k++) begin
            baud_sel = 2'($urandom_range(0, 3));
            w   = DATA_BITS'($urandom);
            par = 1'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            p0  = n_pulses;
            e   = model(w, par, stp);
            send_frame(w, par, stp, bit_clks(baud_sel));
            drive_bit(1'b1, $urandom_range(2, 40));
            wait_frame(o);
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL random_%0d sel=%0d: got %h/%b/%b required %h/%b/%b", k, baud_sel, o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
            n_cmp++; if (n_pulses - p0 !== 1) begin n_fail++; $display("FAIL random_pulses_%0d: got %0d required 1", k, n_pulses - p0); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o, e;
        int   p0;
        logic [DATA_BITS-1:0] w = 8'hB6;
        baud_sel = 2'd3;
        send_frame(8'hE7, good_parity(8'hE7), 1'b0, 64);
        drive_bit(1'b1, 64);
        wait_frame(o);
        p0 = n_pulses;
        drive_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) drive_bit(w[i], 64);
        drive_bit(w[4], 32);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h required 00", bus.data); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_fe: got %b required 0", bus.frame_err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", bus.busy); end
        n_cmp++; if (bus.data_valid !== 1'b0 || bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_pe: got %b/%b required 0/0", bus.data_valid, bus.parity_err); end
        rst = 1'b0;
        drive_bit(1'b1, 3 * 64);
        n_cmp++; if (n_pulses - p0 !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d required 0", n_pulses - p0); end
        e = model(8'h55, good_parity(8'h55), 1'b1);
        send_frame(8'h55, good_parity(8'h55), 1'b1, 64);
        wait_frame(o);
        n_cmp++; if (o !== e) begin n_fail++; $display("FAIL midrst_next_55: got %h/%b/%b required %h/%b/%b", o.data, o.fe, o.pe, e.data, e.fe, e.pe); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_baud_change();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
